// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing for a VGA output: divides the system clock down to a
// pixel-rate enable and runs the horizontal/vertical position counters.
// All decoded outputs (valid, syncs, strobes) are registered from the
// next-state counter values, so they change on the same edge as the counters.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   pixel_tick   one-clk enable every PIX_DIV clks; counters advance on it
//   h_cnt        horizontal position, 0..H_TOTAL-1
//   v_cnt        vertical position, 0..V_TOTAL-1
//   valid        high inside the visible area
//   hsync        active-low horizontal sync
//   vsync        active-low vertical sync
//   line_start   one-clk pulse when the counters land on h_cnt==0
//   frame_start  one-clk pulse when the counters land on (0,0)
module vga_timing_gen #(
    parameter int unsigned PIX_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Decode limits are 11 bits wide so a 1024-wide timing cannot wrap them.
    localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;

    // With PIX_DIV==1 div is stuck at 0 == DIV_LAST, so the tick is always high.
    assign pixel_tick = (div == DIV_LAST);

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (pixel_tick) begin
            if (h_cnt == H_LAST) begin
                h_next = 10'd0;
                v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
    end

    assign h_ext = {1'b0, h_next};
    assign v_ext = {1'b0, v_next};

    // Reset parks the counters on the last position of the frame so that the
    // very first tick after release lands exactly on (0,0).
    always_ff @(posedge clk) begin
        if (!reset) begin
            div         <= '0;
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            valid       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= pixel_tick ? '0 : div + DIV_W'(1);
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            valid       <= (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
            hsync       <= !((h_ext >= HS_START) && (h_ext < HS_END));
            vsync       <= !((v_ext >= VS_START) && (v_ext < VS_END));
            // Gated by the tick so the strobe stays one clk wide even though
            // h_next holds at 0 for PIX_DIV clks.
            line_start  <= pixel_tick && (h_next == 10'd0);
            frame_start <= pixel_tick && (h_next == 10'd0) && (v_next == 10'd0);
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the VGA raster timing that pixel_gen consumes: h_cnt, v_cnt, valid, plus hsync/vsync to the connector.
- Divides the system clock to a pixel-rate enable and runs horizontal and vertical counters.
- Emits line and frame strobes for the game logic and the scrolling logic.
- Sits beside pixel_gen in the top level; fixed 640x480@60 Hz by default.

Parameters:
PIX_DIV, 4, system clocks per pixel (100 MHz to 25 MHz); legal values are 1 or greater
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge)
pixel_tick  output  1  one-clk pulse every PIX_DIV clks; counters advance on it
h_cnt  output  10  horizontal position, 0..H_TOTAL-1
v_cnt  output  10  vertical position, 0..V_TOTAL-1
valid  output  1  high when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
hsync  output  1  active-low horizontal sync
vsync  output  1  active-low vertical sync
line_start  output  1  one-clk pulse in the first clk where h_cnt==0
frame_start  output  1  one-clk pulse in the first clk where h_cnt==0 and v_cnt==0

Behaviour:
- Divider: div register, width clog2(PIX_DIV) (at least 1 bit).
  - div increments every clk and wraps at PIX_DIV-1.
  - pixel_tick = (div==PIX_DIV-1), combinational from div.
  - With PIX_DIV=1, pixel_tick is held high whenever reset is high.
- Horizontal counter: on a clk edge with pixel_tick=1, h_next = (h_cnt==H_TOTAL-1) ? 0 : h_cnt+1.
- Vertical counter: v_next = v_cnt+1 only when h_cnt==H_TOTAL-1; it wraps from V_TOTAL-1 to 0.
- Decode is registered from the next values on the same edge, so every output stays aligned with the counters (zero skew):
  - valid <= (h_next<H_ACTIVE) and (v_next<V_ACTIVE)
  - hsync <= not (H_ACTIVE+H_FP <= h_next < H_ACTIVE+H_FP+H_SYNC), i.e. low for h = 656..751
  - vsync <= not (V_ACTIVE+V_FP <= v_next < V_ACTIVE+V_FP+V_SYNC), i.e. low for v = 490..491
- Hold: with no pixel_tick, h_cnt, v_cnt, valid, hsync and vsync keep their values.
- Strobes:
  - line_start <= pixel_tick and (h_next==0); it is low in all other clks.
  - frame_start <= pixel_tick and (h_next==0) and (v_next==0).
  - Each strobe is exactly one clk wide, whatever PIX_DIV is.
- Reset (reset==0 at a clk edge) sets:
  - div=0
  - h_cnt=H_TOTAL-1 (799), v_cnt=V_TOTAL-1 (524)
  - valid=0, hsync=1, vsync=1
  - line_start=0, frame_start=0
  - These values are the decode of (799,524), so the first tick after reset lands on (0,0).
- First frame after reset release:
  - div counts 1..PIX_DIV-1; the pixel_tick cycle has div==PIX_DIV-1.
  - At the following edge, clock number PIX_DIV after release, counters go to (0,0), valid=1, and line_start and frame_start go high for one clk.
  - This means the first visible pixel is always (0,0) and never partial.
- Reset asserted mid-line or mid-frame: takes effect on the next edge regardless of pixel_tick, and all outputs return to their reset values. No sync pulse is stretched; a truncated sync is acceptable.
- Period: line = H_TOTAL*PIX_DIV clks (3200); frame = H_TOTAL*V_TOTAL*PIX_DIV clks (1,680,000).
- Widths: counters are 10 bits; parameters must satisfy H_TOTAL and V_TOTAL of at most 1024. All comparisons are unsigned.

Test Plan:
- Hold reset=0 for 5 clks -> h_cnt=799, v_cnt=524, valid=0, hsync=1, vsync=1, strobes=0, pixel_tick=0. Release -> pixel_tick high in the 4th clk; (0,0) with valid=1, frame_start=1, line_start=1 in the 5th clk; frame_start=0 in the 6th clk.
- Run one line -> h_cnt steps every 4 clks; valid falls when h_cnt becomes 640; hsync low exactly for h_cnt 656..751 (384 clks); line_start period 3200 clks.
- Run two full frames -> vsync low exactly for v_cnt 490..491 (6400 clks); frame_start period 1,680,000 clks; v_cnt wraps 524->0 on the same edge that h_cnt wraps 799->0.
- Sweep a whole frame -> count of clks with valid=1 and pixel_tick=1 is exactly 307,200; valid is never 1 with h_cnt>=640 or v_cnt>=480.
- Assert reset=0 at h_cnt=700 (during hsync), v_cnt=491 (during vsync) -> next edge gives hsync=1, vsync=1, h_cnt=799, v_cnt=524. After release, the timing repeats scenario 1 exactly.
- Set PIX_DIV=1 -> pixel_tick constantly 1 out of reset; counters advance every clk; frame_start one clk wide with period 420,000 clks.
